// File: rtl/ex_sequencer_pkg.sv
// Shared definitions for the execute-stage sequencer: state encoding and
// default widths. Optional build macro: EX_BYPASS_EN (see ex_sequencer.sv).
package ex_sequencer_pkg;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_RUN  = 2'd1,
        EX_WAIT = 2'd2
    } ex_state_t;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_RD_W       = 5;
    localparam int DEFAULT_BUSY_GUARD = 1;

    // Guard counter holds BUSY_GUARD, which is at most 3.
    localparam int GUARD_W = 2;

endpackage : ex_sequencer_pkg

// File: rtl/ex_wb_slot.sv
// One-entry valid/ready holding register. A fill and a drain on the same
// edge leave the slot full with the new payload. Reusable by the mem stage.
module ex_wb_slot
    import ex_sequencer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RD_W   = DEFAULT_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [RD_W-1:0]   fill_rd,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              ready,
    output logic              free,
    output logic              valid,
    output logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] data
);

    // The slot can take new data when empty or being drained this edge.
    assign free = !valid || ready;

    // Valid flag and payload; the payload holds while full and not drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload is reset as well, not just valid, so the
            // writeback bus shows zeros rather than stale data after reset.
            valid <= 1'b0;
            rd    <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            rd    <= fill_rd;
            data  <= fill_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule : ex_wb_slot

// File: rtl/ex_sequencer.sv
// Execute-stage sequencer: accepts one ALU op per handshake, launches and
// tracks multi-cycle units, and captures results into a writeback slot.
// Optional build macro: EX_BYPASS_EN adds decode-stage forwarding outputs;
// without it the forwarding ports are tied to zero.
module ex_sequencer
    import ex_sequencer_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int RD_W       = DEFAULT_RD_W,
    parameter int BUSY_GUARD = DEFAULT_BUSY_GUARD
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  logic              i_ex_multicycle,
    input  logic [RD_W-1:0]   i_ex_rd,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_unit_busy,
    output logic              o_unit_en,
    output logic              o_stall,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [RD_W-1:0]   o_wb_rd,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_fwd_valid,
    output logic [RD_W-1:0]   o_fwd_rd,
    output logic [DATA_W-1:0] o_fwd_data
);

    ex_state_t          state;
    ex_state_t          next_state;
    logic [GUARD_W-1:0] count;
    logic [GUARD_W-1:0] next_count;
    logic [RD_W-1:0]    pending_rd;
    logic               load_pending;
    logic               slot_free;
    logic               fill;
    logic [RD_W-1:0]    fill_rd;

    // State register, guard counter and destination of the in-flight op.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: non-blocking assignments so every register here samples
            // the values that were present before the edge.
            state      <= EX_IDLE;
            count      <= '0;
            pending_rd <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (load_pending) begin
                pending_rd <= i_ex_rd;
            end
        end
    end

    // Next-state, handshake, unit enable, stall and slot fill decode.
    always_comb begin
        // NOTE: every signal gets a default first; a branch that forgot one
        // would otherwise infer a latch.
        next_state   = state;
        next_count   = count;
        o_ex_ready   = 1'b0;
        o_unit_en    = 1'b0;
        o_stall      = 1'b0;
        fill         = 1'b0;
        fill_rd      = i_ex_rd;
        load_pending = 1'b0;

        unique case (state)
            EX_IDLE: begin
                o_ex_ready = slot_free;
                if (i_ex_valid && slot_free) begin
                    if (i_ex_multicycle) begin
                        // Launch now; the guard covers the late busy flag.
                        o_unit_en    = 1'b1;
                        load_pending = 1'b1;
                        next_count   = GUARD_W'(BUSY_GUARD);
                        next_state   = EX_RUN;
                    end else begin
                        fill = 1'b1;
                    end
                end
            end

            EX_RUN: begin
                o_stall   = 1'b1;
                o_unit_en = 1'b1;
                if (count <= 2'd1) begin
                    next_state = EX_WAIT;
                end else begin
                    next_count = count - 2'd1;
                end
            end

            EX_WAIT: begin
                // Enable and stall drop in the completion cycle so the unit
                // does not relaunch and upstream can move on.
                o_stall   = i_unit_busy;
                o_unit_en = i_unit_busy;
                if (!i_unit_busy) begin
                    fill       = 1'b1;
                    fill_rd    = pending_rd;
                    next_state = EX_IDLE;
                end
            end

            default: begin
                next_state = EX_IDLE;
            end
        endcase
    end

    ex_wb_slot #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_wb_slot (
        .clk       (i_clk),
        .rst       (i_rst),
        .fill      (fill),
        .fill_rd   (fill_rd),
        .fill_data (i_alu_result),
        .ready     (i_wb_ready),
        .free      (slot_free),
        .valid     (o_wb_valid),
        .rd        (o_wb_rd),
        .data      (o_wb_data)
    );

`ifdef EX_BYPASS_EN
    // Forward the slot to decode; x0 destinations are never forwarded.
    assign o_fwd_valid = o_wb_valid && (o_wb_rd != '0);
    assign o_fwd_rd    = o_wb_rd;
    assign o_fwd_data  = o_wb_data;
`else
    assign o_fwd_valid = 1'b0;
    assign o_fwd_rd    = '0;
    assign o_fwd_data  = '0;
`endif

endmodule : ex_sequencer
